vlc_manchester_tx: RTL and testbench
====================================

# vlc_manchester_tx

Transmit-side framer and Manchester line encoder for the visible-light link. It takes payload bytes over a valid/ready byte stream, wraps them in a preamble and start-of-frame delimiter, and drives the LED modulator with a Manchester-coded bit stream. Its half-bit timing is an internal clock-enable derived from `aclk`, with no generated clock, so one bit period matches the receiver's recovered bit clock (6 `aclk` cycles by default).

## Interface
- `HALF_BIT_CYCLES`, 3: `aclk` cycles per Manchester half-bit (≥2); bit period = 2×this.
- `PREAMBLE_BITS`, 16: preamble length in bits, alternating 1,0,1,0… starting with 1 (even, ≥2).
- `SFD`, 8'hD5: start-of-frame delimiter, sent MSB first.
- `GAP_BITS`, 4: inter-frame gap in bit times, line at idle level.
- `aclk` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `s_tdata` in 8: payload byte, sent MSB first.
- `s_tvalid` in 1: `s_tdata`/`s_tlast` valid.
- `s_tready` out 1: byte accepted on `aclk` edge when `s_tvalid & s_tready`.
- `s_tlast` in 1: byte is the last of the frame.
- `led_out` out 1: Manchester line to LED driver, registered.
- `busy` out 1: frame or gap in progress, registered.
- `underflow` out 1: one-cycle pulse, frame aborted for lack of data.

## Operation
- States: IDLE → PREAMBLE → SFD → DATA → GAP → IDLE.
- Manchester convention: bit 1 = low half then high half; bit 0 = high half then low half.
- IDLE: `s_tready`=1, `led_out`=0, `busy`=0, half-bit counter held at 0. On handshake, latch byte and `s_tlast` into the hold register, load the preamble, go to PREAMBLE.
- PREAMBLE: PREAMBLE_BITS bits, then SFD (8 bits), then DATA with the held byte in the shifter.
- DATA byte boundary: in the `aclk` cycle ending the second half of bit 0 (LSB), `s_tready`=1 if the current byte is not last.
  - Valid present: load the new byte; the next bit starts with no gap.
  - Current byte last: go to GAP.
  - Not last and `s_tvalid`=0: pulse `underflow`, go to GAP, drop the frame remainder. A later byte starts a new frame from IDLE.
- `s_tready`=0 in PREAMBLE, SFD, GAP, and all DATA cycles except the boundary.
- GAP: `led_out`=0 for 2×GAP_BITS half-bits, `busy`=1, then IDLE.
- Reset, including mid-frame: on the next edge the state is IDLE, all counters are 0, and `led_out`=0, `busy`=0, `underflow`=0, `s_tready`=0. `s_tready` returns to 1 on the first cycle after reset deasserts.
- Simultaneous `reset` and handshake: reset wins and the byte is not consumed.

## Timing
- Half-bit tick: counter 0..HALF_BIT_CYCLES-1, width $clog2(HALF_BIT_CYCLES). It wraps on the tick and is cleared on entry to PREAMBLE.
- Latency: handshake in IDLE at edge T; `led_out` shows the first preamble half-bit from T+1. Each half-bit is exactly HALF_BIT_CYCLES cycles.
- Frame length, N bytes without underflow: (PREAMBLE_BITS+8+8N)×2×HALF_BIT_CYCLES cycles. The gap adds GAP_BITS×2×HALF_BIT_CYCLES cycles.
- `busy` rises at T+1 and falls on the cycle the state returns to IDLE.
- `underflow` is high for exactly one cycle, coincident with the first GAP cycle.
- Preamble bit counter width is $clog2(PREAMBLE_BITS+1). The bit-in-byte counter is 3 bits and wraps 7→0 at the byte boundary.

## Structure
- Package `vlc_pkg`: state enum `tx_state_t`, default SFD constant, Manchester polarity constant. This package is shared with the receiver decoder.
- Sub-module `half_bit_tick`: parameterised enable divider with synchronous clear, output a one-cycle `tick`.
- The top level holds the FSM, the shifter, the hold register and the counters.

## Test plan
- Reset, then a single byte 0xA5 with `s_tlast`=1, default parameters:
  - `led_out` is 1010… Manchester for 96 cycles, then D5, then A5.
  - First A5 bit is 0 for 3 cycles, then 1 for 3 cycles.
  - `busy` is high for 192+24 cycles.
- Three bytes 0x00, 0xFF, 0x3C with `s_tvalid` held high: `s_tready` pulses exactly at each byte boundary, with no idle half-bits between bytes.
- Two bytes, `s_tvalid` dropped before the second: `underflow` pulses once after byte one, the GAP follows, and the next byte starts a fresh preamble.
- Reset asserted mid-SFD: next cycle all outputs are at reset values; after release a new frame is correctly framed.
- HALF_BIT_CYCLES=2, PREAMBLE_BITS=4, GAP_BITS=1: frame and gap lengths match the Timing formulas exactly.
- `s_tvalid` asserted in the same cycle reset deasserts: the byte is not accepted until `s_tready`=1 on the following cycle.

Source files
------------

// File: rtl/vlc_pkg.sv
// Shared definitions for the visible-light link transmitter and receiver.
package vlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_t;

  localparam logic [7:0] SFD_DEFAULT = 8'hD5;

  // Line level during the first half of a '1' bit; a '0' bit is the mirror image.
  localparam logic MANCH_ONE_FIRST_HALF = 1'b0;

  // Line level for a data bit in the given half (0 = first half, 1 = second half).
  function automatic logic manch_level(input logic data_bit, input logic second_half);
    return data_bit ^ second_half ^ ~MANCH_ONE_FIRST_HALF;
  endfunction

endpackage

// File: rtl/vlc_manchester_tx_if.sv
// Payload byte stream into the Manchester transmitter.
interface vlc_manchester_tx_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input  s_tready);
  modport slave  (input  s_tdata, input  s_tvalid, input  s_tlast, output s_tready);
endinterface

// File: rtl/vlc_manchester_tx_half_bit_tick.sv
// Clock-enable divider: one-cycle tick every CYCLES aclk cycles, held at zero while cleared.
module half_bit_tick #(
  parameter int CYCLES = 3
) (
  input  logic aclk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int            CW       = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: zero while cleared, otherwise count up and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/vlc_manchester_tx.sv
// Frame builder (preamble, SFD, payload, gap) and Manchester line encoder.
module vlc_manchester_tx
  import vlc_pkg::*;
#(
  parameter int         HALF_BIT_CYCLES = 3,
  parameter int         PREAMBLE_BITS   = 16,
  parameter logic [7:0] SFD             = SFD_DEFAULT,
  parameter int         GAP_BITS        = 4
) (
  input  logic               aclk,
  input  logic               reset,
  vlc_manchester_tx_if.slave bus,
  output logic               led_out,
  output logic               busy,
  output logic               underflow
);
  localparam int            PW       = $clog2(PREAMBLE_BITS + 1);
  localparam int            GW       = $clog2(2 * GAP_BITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * GAP_BITS - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};

  tx_state_t     state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          half_q, half_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          cur_last_q, cur_last_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          underflow_q, underflow_d;
  logic          ready_en_q;
  logic          tick_s, bit_end_s, ready_s, hs_s;

  half_bit_tick #(.CYCLES(HALF_BIT_CYCLES)) u_tick (
    .aclk   (aclk),
    .reset  (reset),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick_s)
  );

  assign bit_end_s = tick_s & half_q;

  // Ready in IDLE and at a non-last byte boundary; never while in or just out of reset.
  always_comb begin
    ready_s = 1'b0;
    if (reset || !ready_en_q) begin
      ready_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      ready_s = 1'b1;
    end else if (state_q == ST_DATA && bit_end_s && bit_cnt_q == 3'd7 && !cur_last_q) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign bus.s_tready = ready_s;
  assign hs_s         = bus.s_tvalid & ready_s;

  // Frame sequencing: state, counters, shifter and hold register.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    cur_last_d  = cur_last_q;
    underflow_d = 1'b0;
    if (state_q == ST_IDLE) begin
      half_d = 1'b0;
    end else if (tick_s) begin
      half_d = ~half_q;
    end else begin
      half_d = half_q;
    end
    case (state_q)
      ST_IDLE: begin
        pre_cnt_d = PRE_ZERO;
        bit_cnt_d = 3'd0;
        gap_cnt_d = GAP_ZERO;
        if (hs_s) begin
          hold_d      = bus.s_tdata;
          hold_last_d = bus.s_tlast;
          state_d     = ST_PREAMBLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (bit_end_s && pre_cnt_q == PRE_LAST) begin
          pre_cnt_d = PRE_ZERO;
          shift_d   = SFD;
          state_d   = ST_SFD;
        end else if (bit_end_s) begin
          pre_cnt_d = pre_cnt_q + PRE_ONE;
        end else begin
          pre_cnt_d = pre_cnt_q;
        end
      end
      ST_SFD: begin
        if (bit_end_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            shift_d    = hold_q;
            cur_last_d = hold_last_q;
            state_d    = ST_DATA;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            shift_d = {shift_q[6:0], 1'b0};
          end else if (cur_last_q) begin
            state_d = ST_GAP;
          end else if (bus.s_tvalid) begin
            shift_d    = bus.s_tdata;
            cur_last_d = bus.s_tlast;
          end else begin
            underflow_d = 1'b1;
            state_d     = ST_GAP;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_GAP: begin
        if (tick_s && gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = GAP_ZERO;
          state_d   = ST_IDLE;
        end else if (tick_s) begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end else begin
          gap_cnt_d = gap_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level and busy are derived from the upcoming state so the registers line up with it.
  always_comb begin
    led_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_PREAMBLE: led_d = manch_level(~pre_cnt_d[0], half_d);
      ST_SFD:      led_d = manch_level(shift_d[7], half_d);
      ST_DATA:     led_d = manch_level(shift_d[7], half_d);
      default:     led_d = 1'b0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= PRE_ZERO;
      bit_cnt_q   <= 3'd0;
      gap_cnt_q   <= GAP_ZERO;
      half_q      <= 1'b0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_last_q <= 1'b0;
      cur_last_q  <= 1'b0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      half_q      <= half_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      cur_last_q  <= cur_last_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign led_out   = led_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vlc_manchester_tx.sv
// Self-checking bench: per-cycle comparison of {led_out, busy, underflow, s_tready}
// against a waveform built from the frame rules (bits -> half-bit levels -> cycles).
module tb_vlc_manchester_tx;

  logic       aclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       sel = 1'b0;
  logic       led0, busy0, uf0, led1, busy1, uf1;
  logic [3:0] obs_s;
  logic [7:0] sfd_v = 8'hD5;
  logic [7:0] stim_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 aclk = ~aclk;

  vlc_manchester_tx_if bus0 ();
  vlc_manchester_tx_if bus1 ();

  assign bus0.s_tdata  = tdata;
  assign bus0.s_tvalid = tvalid;
  assign bus0.s_tlast  = tlast;
  assign bus1.s_tdata  = tdata;
  assign bus1.s_tvalid = tvalid;
  assign bus1.s_tlast  = tlast;

  vlc_manchester_tx #(.HALF_BIT_CYCLES(3), .PREAMBLE_BITS(16), .SFD(8'hD5), .GAP_BITS(4)) dut (
    .aclk(aclk), .reset(reset), .bus(bus0), .led_out(led0), .busy(busy0), .underflow(uf0));

  vlc_manchester_tx #(.HALF_BIT_CYCLES(2), .PREAMBLE_BITS(4), .SFD(8'hD5), .GAP_BITS(1)) dut_s (
    .aclk(aclk), .reset(reset), .bus(bus1), .led_out(led1), .busy(busy1), .underflow(uf1));

  assign obs_s = sel ? {led1, busy1, uf1, bus1.s_tready} : {led0, busy0, uf0, bus0.s_tready};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reset for one cycle with a byte offered; it must not be taken, and ready returns one cycle later.
  task automatic apply_reset(input string tag);
    @(posedge aclk); #1;
    reset = 1'b1; tvalid = 1'b1; tdata = 8'($urandom); tlast = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    check_val({tag, "_after_edge"}, {28'd0, obs_s}, 32'h0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check_val({tag, "_ready_back"}, {28'd0, obs_s}, 32'h1);
    tvalid = 1'b0;
  endtask

  // Send a frame of nbytes bytes (stim_q, or random if empty); only nsent are offered in time.
  task automatic run_frame(input int nbytes, input int nsent, input int abort_at);
    logic [7:0] bytes [$];
    logic       bits_q [$];
    logic [3:0] exp_q [$];
    int         h, pb, gb, idx, bidx, busy_cnt;
    logic       hs;
    h  = sel ? 2 : 3;
    pb = sel ? 4 : 16;
    gb = sel ? 1 : 4;
    for (int i = 0; i < nbytes; i++) begin
      if (stim_q.size() > 0) bytes.push_back(stim_q.pop_front());
      else bytes.push_back(8'($urandom));
    end
    for (int i = 0; i < pb; i++) bits_q.push_back((i % 2) == 0);
    for (int i = 7; i >= 0; i--) bits_q.push_back(sfd_v[i]);
    for (int k = 0; k < nsent; k++) begin
      for (int i = 7; i >= 0; i--) bits_q.push_back(bytes[k][i]);
    end
    foreach (bits_q[i]) begin
      for (int j = 0; j < h; j++) exp_q.push_back({~bits_q[i], 1'b1, 1'b0, 1'b0});
      for (int j = 0; j < h; j++) exp_q.push_back({bits_q[i], 1'b1, 1'b0, 1'b0});
    end
    for (int k = 0; k < nsent; k++) begin
      if (k != nbytes - 1) begin
        idx = (pb + 8 + 8 * (k + 1)) * 2 * h - 1;
        exp_q[idx] = exp_q[idx] | 4'b0001;
      end
    end
    for (int i = 0; i < 2 * gb * h; i++) begin
      exp_q.push_back((i == 0 && nsent < nbytes) ? 4'b0110 : 4'b0100);
    end

    @(posedge aclk); #1;
    tdata = bytes[0]; tlast = (nbytes == 1); tvalid = 1'b1;
    @(negedge aclk);
    check_val($sformatf("s%0d_idle_pre", sel), {28'd0, obs_s}, 32'h1);
    @(posedge aclk); #1;
    bidx = 1;
    if (bidx < nsent) begin
      tdata = bytes[bidx]; tlast = (bidx == nbytes - 1); tvalid = 1'b1;
    end else begin
      tvalid = 1'b0; tdata = 8'($urandom);
    end
    busy_cnt = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge aclk);
      check_val($sformatf("s%0d_cyc%0d", sel, c), {28'd0, obs_s}, {28'd0, exp_q[c]});
      busy_cnt += int'(obs_s[2]);
      if (c == abort_at) return;
      hs = exp_q[c][0] & tvalid;
      @(posedge aclk); #1;
      if (hs) begin
        bidx++;
        if (bidx < nsent) begin
          tdata = bytes[bidx]; tlast = (bidx == nbytes - 1); tvalid = 1'b1;
        end else begin
          tvalid = 1'b0; tdata = 8'($urandom);
        end
      end
    end
    @(negedge aclk);
    check_val($sformatf("s%0d_idle_post", sel), {28'd0, obs_s}, 32'h1);
    check_val($sformatf("s%0d_busy_len", sel), busy_cnt, exp_q.size());
  endtask

  initial begin
    int n, m;
    sel = 1'b0;
    apply_reset("rst0");

    // Single byte 0xA5, last.
    stim_q.push_back(8'hA5);
    run_frame(1, 1, -1);

    // Back-to-back bytes with valid held high.
    stim_q.push_back(8'h00); stim_q.push_back(8'hFF); stim_q.push_back(8'h3C);
    run_frame(3, 3, -1);

    // Underflow after the first byte, then a fresh frame.
    run_frame(2, 1, -1);
    run_frame(1, 1, -1);

    // Random frames, some truncated.
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 4);
      m = (n > 1 && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, n - 1) : n;
      run_frame(n, m, -1);
    end

    // Reset in the middle of the SFD, then a correctly framed new frame.
    run_frame(2, 2, 16 * 6 + 10);
    apply_reset("rst_sfd");
    run_frame(2, 2, -1);

    // Small parameter set.
    sel = 1'b1;
    apply_reset("rst1");
    run_frame(2, 2, -1);
    run_frame(3, 2, -1);
    run_frame(1, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
